// File: rtl/iscbdiv_ctrl.sv
// Sequencer for the in-stream correlation-based stochastic divider: LFSR stream generation, warm-up, counting run, result handshake.
// Optional operand rejection (divisor==0 or dividend>divisor) is enabled with `define ISCBDIV_CTRL_CHK_EN.
module iscbdiv_ctrl #(
  parameter int WIDTH  = 8,
  parameter int WARMUP = 4,
  parameter int SEED   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_dividend,
  input  logic [WIDTH-1:0] op_divisor,
  output logic             dividend,
  output logic             divisor,
  output logic             sel,
  input  logic             quotient,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             err,
  output logic             busy
);

  // Cycle counter must hold both WARMUP-1 (up to 254) and 2^WIDTH-1.
  localparam int CW = ((WIDTH > 8) ? WIDTH : 8) + 1;
  localparam logic [CW-1:0]    WARM_LAST = CW'(WARMUP - 1);
  localparam logic [CW-1:0]    RUN_LAST  = CW'((2 ** WIDTH) - 1);
  localparam logic [WIDTH-1:0] SEED_W    = WIDTH'(SEED);

  function automatic logic [15:0] tap_mask(input int w);
    case (w)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      default: return 16'hD008;
    endcase
  endfunction

  localparam logic [15:0]      TAPS16 = tap_mask(WIDTH);
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

  typedef enum logic [1:0] {S_IDLE, S_WARM, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_result;
  logic [CW-1:0]    r_cyc;
  logic [WIDTH:0]   r_ones;
  logic             r_dividend;
  logic             r_divisor;
  logic             r_sel;
  logic             r_out_valid;
  logic             r_err;
  logic             r_busy;

  logic             w_fb;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [WIDTH:0]   w_ones_nxt;
  logic             w_gen;
  logic             w_reject;

  assign w_fb       = ^(r_lfsr & TAPS);
  assign w_lfsr_nxt = {r_lfsr[WIDTH-2:0], w_fb};
  assign w_ones_nxt = r_ones + (WIDTH+1)'(quotient);
  // Streams drop to 0 on the same edge the FSM leaves RUN, so DONE never sees a stale stream bit.
  assign w_gen      = (r_state == S_WARM) || ((r_state == S_RUN) && (r_cyc != RUN_LAST));

`ifdef ISCBDIV_CTRL_CHK_EN
  assign w_reject = (op_divisor == '0) || (op_dividend > op_divisor);
`else
  assign w_reject = 1'b0;
`endif

  assign in_ready  = rst_n & (r_state == S_IDLE);
  assign dividend  = r_dividend;
  assign divisor   = r_divisor;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign err       = r_err;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_lfsr      <= SEED_W;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_result    <= '0;
      r_cyc       <= '0;
      r_ones      <= '0;
      r_dividend  <= 1'b0;
      r_divisor   <= 1'b0;
      r_sel       <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_dividend <= w_gen & (r_dvd > r_lfsr);
      r_divisor  <= w_gen & (r_dvs > r_lfsr);
      r_sel      <= w_gen & (r_lfsr[0] ^ r_lfsr[WIDTH-1]);
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dvd  <= op_dividend;
            r_dvs  <= op_divisor;
            r_lfsr <= SEED_W;
            r_cyc  <= '0;
            r_ones <= '0;
            r_busy <= 1'b1;
            if (w_reject) begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_result    <= '1;
              r_err       <= 1'b1;
            end else begin
              r_state <= S_WARM;
            end
          end
        end
        S_WARM: begin
          r_lfsr <= w_lfsr_nxt;
          if (r_cyc == WARM_LAST) begin
            r_cyc   <= '0;
            r_state <= S_RUN;
          end else begin
            r_cyc <= r_cyc + CW'(1);
          end
        end
        S_RUN: begin
          r_lfsr <= w_lfsr_nxt;
          r_ones <= w_ones_nxt;
          r_cyc  <= r_cyc + CW'(1);
          if (r_cyc == RUN_LAST) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_ones_nxt[WIDTH] ? '1 : w_ones_nxt[WIDTH-1:0];
            r_err       <= 1'b0;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iscbdiv_ctrl.sv
// Scoreboard bench for iscbdiv_ctrl: stimulus pushes expected {result, err, latency}, a negedge monitor pops on handshake.
module tb_iscbdiv_ctrl;
  localparam int W  = 8;
  localparam int WU = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] op_dividend = '0;
  logic [W-1:0] op_divisor = '0;
  logic         in_ready, dividend, divisor, sel, out_valid, err, busy;
  logic [W-1:0] result;
  logic         quotient;

  int cyc = 0;
  int qmode = 0;
  int drop_a = -1;
  int drop_b = -1;
  int n_vec = 0;
  int n_bad = 0;
  logic prev_ov = 1'b0;
  logic chk_idle = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    logic         e;
    int           lat;
    int           acc;
  } exp_t;
  exp_t sb[$];

  iscbdiv_ctrl #(.WIDTH(W), .WARMUP(WU), .SEED(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_dividend(op_dividend), .op_divisor(op_divisor),
    .dividend(dividend), .divisor(divisor), .sel(sel), .quotient(quotient),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Quotient stub: 0=const0, 1=const1 with optional drops, 2=alternating, 3..5 loop back a stream.
  always_comb begin
    quotient = 1'b0;
    case (qmode)
      1: quotient = !((cyc == drop_a) || (cyc == drop_b));
      2: quotient = cyc[0];
      3: quotient = dividend;
      4: quotient = divisor;
      5: quotient = sel;
      default: quotient = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (chk_idle) begin
        check("post_hs_busy", busy, 0);
        check("post_hs_in_ready", in_ready, 1);
        check("post_hs_out_valid", out_valid, 0);
      end
      if (out_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_out_valid: got result %0d with no pending vector", result);
        end else begin
          if (!prev_ov) check("latency", cyc - sb[0].acc, sb[0].lat);
          check("result", result, sb[0].res);
          check("err", err, sb[0].e);
          if (out_ready) void'(sb.pop_front());
        end
      end
      prev_ov  <= out_valid;
      chk_idle <= out_valid & out_ready;
    end else begin
      prev_ov  <= 1'b0;
      chk_idle <= 1'b0;
    end
  end

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, output int acc);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 1000) begin
      @(negedge clk);
      t++;
    end
    check("accept_ready_timeout", in_ready, 1);
    op_dividend = a;
    op_divisor  = b;
    in_valid    = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    acc = cyc;
  endtask

  task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b, input int qm, input int nd,
                         input logic [W-1:0] er, input logic ee, input int lat, input int bp);
    int acc, t;
    logic tog;
    qmode     = qm;
    out_ready = (bp == 0);
    accept(a, b, acc);
    drop_a = (nd > 0) ? acc + 100 : -1;
    drop_b = (nd > 1) ? acc + 150 : -1;
    sb.push_back('{er, ee, lat, acc});
    tog = 1'b0;
    t = 0;
    while (!out_valid && t < 400) begin
      @(negedge clk);
      tog |= dividend | divisor;
      t++;
    end
    check("out_valid_timeout", out_valid, 1);
    if (ee) check("reject_streams_quiet", tog, 0);
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      in_valid    = i[0];
      op_dividend = W'(i * 7);
      op_divisor  = W'(i * 3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("busy_drop_timeout", busy, 0);
    qmode = 0;
  endtask

  initial begin
    int acc;
    #2;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_err", err, 0);
    check("rst_streams", {dividend, divisor, sel}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    run_vec(8'd10, 8'd20, 1, 0, 8'd255, 1'b0, 260, 0);  // 256 ones saturates
    run_vec(8'd10, 8'd20, 0, 0, 8'd0,   1'b0, 260, 0);
    run_vec(8'd10, 8'd20, 1, 1, 8'd255, 1'b0, 260, 0);  // 255 ones, no clamp
    run_vec(8'd10, 8'd20, 1, 2, 8'd254, 1'b0, 260, 0);
    run_vec(8'd10, 8'd20, 2, 0, 8'd128, 1'b0, 260, 0);
    // Loopback: 256 consecutive LFSR states = all nonzero values plus a repeat of 0x08.
    run_vec(8'd64,  8'd128, 3, 0, 8'd64,  1'b0, 260, 0);
    run_vec(8'd200, 8'd200, 3, 0, 8'd200, 1'b0, 260, 0);
    run_vec(8'd0,   8'd1,   3, 0, 8'd0,   1'b0, 260, 0);
    run_vec(8'd255, 8'd255, 3, 0, 8'd255, 1'b0, 260, 0);
    run_vec(8'd0,   8'd128, 4, 0, 8'd128, 1'b0, 260, 0);
    run_vec(8'd10,  8'd20,  5, 0, 8'd128, 1'b0, 260, 0);
    run_vec(8'd64,  8'd128, 3, 0, 8'd64,  1'b0, 260, 20);  // backpressure
`ifdef ISCBDIV_CTRL_CHK_EN
    run_vec(8'd100, 8'd50, 1, 0, 8'd255, 1'b1, 0, 0);
    run_vec(8'd0,   8'd0,  1, 0, 8'd255, 1'b1, 0, 0);
    run_vec(8'd100, 8'd50, 1, 0, 8'd255, 1'b1, 0, 15);
`else
    run_vec(8'd100, 8'd50, 1, 0, 8'd255, 1'b0, 260, 0);
    run_vec(8'd0,   8'd0,  0, 0, 8'd0,   1'b0, 260, 0);
`endif

    // Reset in RUN cycle 100: count discarded, no result for this pair.
    qmode = 1;
    accept(8'd10, 8'd20, acc);
    repeat (WU + 100) @(posedge clk);
    #1;
    check("mid_run_busy", busy, 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_streams", {dividend, divisor, sel}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    qmode = 0;
    @(negedge clk);
    check("rerelease_in_ready", in_ready, 1);
    run_vec(8'd64, 8'd128, 3, 0, 8'd64, 1'b0, 260, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
